ansi_term_decoder: RTL and testbench
====================================

// Module: ansi_term_decoder
// PURPOSE
//  Terminal-side decoder for the ANSI byte stream the game view emits.
//  Parses bytes into draw commands for a character framebuffer or a golden-frame checker:
//  CSI cursor moves, erase, SGR colour, and printable/UTF-8 glyphs.
//  Sits downstream of the view's byte output; one command is emitted per visible cell write or clear.
// PARAMETERS
//  MAX_ROW  64   last visible row (1-based); writes with row > MAX_ROW are clipped
//  MAX_COL  200  last visible column (1-based); writes with col > MAX_COL are clipped
//  SUB_CH   8'h7F  glyph code emitted for any UTF-8 lead byte (e.g. the pipe block glyph)
// PORTS
//  clk        in   1  clock
//  rst_n      in   1  asynchronous active-low reset
//  in_data    in   8  stream byte
//  in_valid   in   1  in_data valid
//  in_ready   out  1  byte accepted when in_valid & in_ready; = ~out_valid | out_ready
//  out_valid  out  1  command valid; held with all out_* stable until out_ready
//  out_ready  in   1  consumer accepts command
//  out_op     out  1  0 = PUTC, 1 = CLEAR (whole screen)
//  out_row    out  8  PUTC row, 1-based
//  out_col    out  8  PUTC column, 1-based
//  out_ch     out  8  PUTC character code
//  out_fg     out  3  PUTC foreground colour (SGR 30+n -> n)
//  out_bold   out  1  PUTC bold attribute
// BEHAVIOUR
//  Reset (async, rst_n=0): state GROUND, cursor (1,1), fg=7, bold=0, params cleared;
//   out_valid=0 and all out_* = 0. Reset mid-sequence discards the partial sequence.
//  Latency: byte accepted in cycle N -> out_valid=1 in cycle N+1 when it produces a command.
//   Bytes producing no command update state only.
//  FSM GROUND:
//   0x20-0x7E: PUTC at cursor with current fg/bold; col <= col+1, saturating at 255.
//   0xC0-0xFF (UTF-8 lead): PUTC with ch=SUB_CH; col+1. 0x80-0xBF: discarded, no advance.
//   0x0D: col <= 1. 0x0A: row <= row+1 (saturating at 255), col <= 1.
//   0x1B: go to ESC. Other C0 bytes: ignored.
//   PUTC with row>MAX_ROW or col>MAX_COL: no command emitted; cursor still advances.
//  FSM ESC: '[' -> CSI, clear p0/p1, idx=0, bad=0. 0x1B -> stay ESC. Any other byte -> GROUND, discarded.
//  FSM CSI:
//   '0'-'9': p[idx] <= p[idx]*10 + d, saturating at 255 (no 8-bit wrap).
//   ';': idx <= 1; a further ';' when idx=1 sets bad (extra params unsupported).
//   0x20-0x2F, 0x3A, 0x3C-0x3F: set bad. 0x1B: restart -> ESC, sequence dropped.
//   0x40-0x7E (final): if bad, discard; else execute; then -> GROUND.
//   C0 bytes other than ESC: ignored, stay in CSI.
//  Execution:
//   'H'/'f': row <= max(p0,1), col <= max(p1,1); a missing or zero param counts as 1.
//    "ESC[24;0H" -> (24,1).
//   'J': p0==2 emits CLEAR; cursor unchanged. Other p0: ignored.
//   'm': p0 then p1 (if idx=1) in order; 0 -> fg=7, bold=0; 1 -> bold=1; 30-37 -> fg=p-30;
//    others ignored. Empty "ESC[m" = reset.
//   Any other final byte: ignored.
//  Backpressure: a byte is consumed only when in_ready. While out_valid & ~out_ready, in_ready=0 and
//   no state changes. If out_ready=1 with out_valid=1, the new byte is accepted in the same cycle
//   the old command retires; back-to-back PUTCs sustain 1 command/cycle.
//  CLEAR carries out_row/out_col/out_ch/out_fg/out_bold = 0.
// TESTING
//  T1 reset, bytes "AB", out_ready=1 -> PUTC(1,1,'A',fg7,b0) then PUTC(1,2,'B'); one command per cycle.
//  T2 "\033[1;33m\033[5;10H<" -> PUTC(5,10,'<',fg3,bold1); "\033[0m@" -> PUTC(5,11,'@',fg7,b0).
//  T3 "\033[2J\033[H" -> single CLEAR, cursor (1,1); "\033[999;3H" -> cursor (255,3), next PUTC clipped.
//  T4 "\033[3;198H" then bytes E2 96 88 'x' 'y' 'z' -> PUTC(3,198,7F), PUTC(3,199,'x'),
//     PUTC(3,200,'y'), 'z' clipped.
//  T5 hold out_ready=0 for 5 cycles after "Q" with "R" pending -> in_ready=0, out_* stable;
//     release -> Q retires, then R at (1,2).
//  T6 "\033[?25h" and "\033X" -> no commands, FSM in GROUND; rst_n pulse after "\033[1" -> next "m"
//     prints PUTC('m') at (1,1).

Source files
------------

// File: rtl/ansi_term_if.sv
// Byte-in / command-out handshake bundle for the ANSI terminal decoder.
// slave is the decoder side, master is the stream source plus command consumer.
interface ansi_term_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       out_op;
    logic [7:0] out_row;
    logic [7:0] out_col;
    logic [7:0] out_ch;
    logic [2:0] out_fg;
    logic       out_bold;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_valid, out_op, out_row, out_col, out_ch, out_fg, out_bold
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_valid, out_op, out_row, out_col, out_ch, out_fg, out_bold
    );
endinterface

// File: rtl/ansi_term_decoder.sv
// Parses an ANSI byte stream (CSI cursor/erase/SGR, printable and UTF-8 lead bytes)
// into PUTC / CLEAR draw commands with a one-entry registered output.
module ansi_term_decoder #(
    parameter int unsigned MAX_ROW = 64,
    parameter int unsigned MAX_COL = 200,
    parameter logic [7:0]  SUB_CH  = 8'h7F
) (
    input logic        clk,
    input logic        rst_n,
    ansi_term_if.slave bus
);

    typedef enum logic [1:0] {StGround, StEsc, StCsi} state_e;

    localparam logic [7:0] MaxRow = 8'(MAX_ROW);
    localparam logic [7:0] MaxCol = 8'(MAX_COL);

    state_e     state_q, state_d;
    logic [7:0] row_q, row_d, col_q, col_d;
    logic [2:0] fg_q, fg_d;
    logic       bold_q, bold_d;
    logic [7:0] p0_q, p0_d, p1_q, p1_d;
    logic       idx_q, idx_d, bad_q, bad_d;

    logic       out_valid_q, out_valid_d, out_op_q, out_op_d;
    logic [7:0] out_row_q, out_row_d, out_col_q, out_col_d, out_ch_q, out_ch_d;
    logic [2:0] out_fg_q, out_fg_d;
    logic       out_bold_q, out_bold_d;

    logic        in_ready, accept, put;
    logic [7:0]  put_ch, cur_p, acc_sat;
    logic [11:0] acc;
    logic [3:0]  attr;

    // attr is {bold, fg}; applies one SGR parameter.
    function automatic logic [3:0] sgr(input logic [7:0] p, input logic [3:0] a);
        logic [7:0] n;
        n = p - 8'd30;
        if (p == 8'd0) begin
            return {1'b0, 3'd7};
        end else if (p == 8'd1) begin
            return {1'b1, a[2:0]};
        end else if (p >= 8'd30 && p <= 8'd37) begin
            return {a[3], n[2:0]};
        end
        return a;
    endfunction

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        fg_d        = fg_q;
        bold_d      = bold_q;
        p0_d        = p0_q;
        p1_d        = p1_q;
        idx_d       = idx_q;
        bad_d       = bad_q;
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_ch_d    = out_ch_q;
        out_fg_d    = out_fg_q;
        out_bold_d  = out_bold_q;

        in_ready = ~out_valid_q | bus.out_ready;
        accept   = bus.in_valid & in_ready;
        put      = 1'b0;
        put_ch   = bus.in_data;
        cur_p    = idx_q ? p1_q : p0_q;
        acc      = 12'(cur_p) * 12'd10 + 12'(bus.in_data[3:0]);
        acc_sat  = (acc > 12'd255) ? 8'hFF : acc[7:0];
        attr     = {bold_q, fg_q};

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            unique case (state_q)
                StGround: begin
                    if (bus.in_data >= 8'h20 && bus.in_data <= 8'h7E) begin
                        put = 1'b1;
                    end else if (bus.in_data >= 8'hC0) begin
                        put    = 1'b1;
                        put_ch = SUB_CH;
                    end else if (bus.in_data == 8'h0D) begin
                        col_d = 8'd1;
                    end else if (bus.in_data == 8'h0A) begin
                        row_d = (row_q == 8'hFF) ? 8'hFF : row_q + 8'd1;
                        col_d = 8'd1;
                    end else if (bus.in_data == 8'h1B) begin
                        state_d = StEsc;
                    end
                end
                StEsc: begin
                    if (bus.in_data == 8'h5B) begin
                        state_d = StCsi;
                        p0_d    = 8'd0;
                        p1_d    = 8'd0;
                        idx_d   = 1'b0;
                        bad_d   = 1'b0;
                    end else if (bus.in_data != 8'h1B) begin
                        state_d = StGround;
                    end
                end
                StCsi: begin
                    if (bus.in_data >= 8'h30 && bus.in_data <= 8'h39) begin
                        if (idx_q) p1_d = acc_sat;
                        else       p0_d = acc_sat;
                    end else if (bus.in_data == 8'h3B) begin
                        if (idx_q) bad_d = 1'b1;
                        else       idx_d = 1'b1;
                    end else if ((bus.in_data >= 8'h20 && bus.in_data <= 8'h2F) ||
                                 bus.in_data == 8'h3A ||
                                 (bus.in_data >= 8'h3C && bus.in_data <= 8'h3F)) begin
                        bad_d = 1'b1;
                    end else if (bus.in_data == 8'h1B) begin
                        state_d = StEsc;
                    end else if (bus.in_data >= 8'h40 && bus.in_data <= 8'h7E) begin
                        state_d = StGround;
                        if (!bad_q) begin
                            case (bus.in_data)
                                8'h48, 8'h66: begin
                                    row_d = (p0_q == 8'd0) ? 8'd1 : p0_q;
                                    col_d = (p1_q == 8'd0) ? 8'd1 : p1_q;
                                end
                                8'h4A: begin
                                    if (p0_q == 8'd2) begin
                                        out_valid_d = 1'b1;
                                        out_op_d    = 1'b1;
                                        out_row_d   = 8'd0;
                                        out_col_d   = 8'd0;
                                        out_ch_d    = 8'd0;
                                        out_fg_d    = 3'd0;
                                        out_bold_d  = 1'b0;
                                    end
                                end
                                8'h6D: begin
                                    attr = sgr(p0_q, attr);
                                    if (idx_q) attr = sgr(p1_q, attr);
                                    fg_d   = attr[2:0];
                                    bold_d = attr[3];
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: state_d = StGround;
            endcase
        end

        // Clipped writes still move the cursor so later in-range cells land correctly.
        if (put) begin
            if (row_q <= MaxRow && col_q <= MaxCol) begin
                out_valid_d = 1'b1;
                out_op_d    = 1'b0;
                out_row_d   = row_q;
                out_col_d   = col_q;
                out_ch_d    = put_ch;
                out_fg_d    = fg_q;
                out_bold_d  = bold_q;
            end
            col_d = (col_q == 8'hFF) ? 8'hFF : col_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StGround;
            row_q       <= 8'd1;
            col_q       <= 8'd1;
            fg_q        <= 3'd7;
            bold_q      <= 1'b0;
            p0_q        <= 8'd0;
            p1_q        <= 8'd0;
            idx_q       <= 1'b0;
            bad_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_op_q    <= 1'b0;
            out_row_q   <= 8'd0;
            out_col_q   <= 8'd0;
            out_ch_q    <= 8'd0;
            out_fg_q    <= 3'd0;
            out_bold_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            fg_q        <= fg_d;
            bold_q      <= bold_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            idx_q       <= idx_d;
            bad_q       <= bad_d;
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_ch_q    <= out_ch_d;
            out_fg_q    <= out_fg_d;
            out_bold_q  <= out_bold_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_op    = out_op_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_fg    = out_fg_q;
    assign bus.out_bold  = out_bold_q;

endmodule

// File: tb/tb_ansi_term_decoder.sv
// Bench for ansi_term_decoder: directed scenarios plus random byte streams, all checked
// against a terminal model that buffers whole CSI sequences and parses them on the final byte.
module tb_ansi_term_decoder;
    localparam int         MaxRow = 64;
    localparam int         MaxCol = 200;
    localparam logic [7:0] SubCh  = 8'h7F;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ansi_term_if bus ();

    ansi_term_decoder #(
        .MAX_ROW(MaxRow),
        .MAX_COL(MaxCol),
        .SUB_CH (SubCh)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int n_checks = 0;
    int n_fail = 0;
    int ready_mode = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference terminal model
    int         m_mode;  // 0 text, 1 after ESC, 2 inside CSI
    int         m_row, m_col, m_fg, m_bold;
    int         m_buf[$];
    logic [28:0] exp_q[$];

    function automatic logic [28:0] mk_cmd(input int op, input int r, input int c, input int ch,
                                           input int fg, input int b);
        return {1'(op), 8'(r), 8'(c), 8'(ch), 3'(fg), 1'(b)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_row = 1; m_col = 1; m_fg = 7; m_bold = 0;
        m_buf.delete();
        exp_q.delete();
    endtask

    task automatic model_putc(input int ch);
        if (m_row <= MaxRow && m_col <= MaxCol)
            exp_q.push_back(mk_cmd(0, m_row, m_col, ch, m_fg, m_bold));
        if (m_col < 255) m_col++;
    endtask

    task automatic model_sgr(input int p);
        if (p == 0) begin
            m_fg = 7; m_bold = 0;
        end else if (p == 1) begin
            m_bold = 1;
        end else if (p >= 30 && p <= 37) begin
            m_fg = p - 30;
        end
    endtask

    task automatic model_exec(input int fin);
        int fields[$];
        int cur;
        bit ok;
        cur = 0;
        ok = 1;
        foreach (m_buf[i]) begin
            if (m_buf[i] >= 8'h30 && m_buf[i] <= 8'h39) begin
                cur = cur * 10 + (m_buf[i] - 8'h30);
                if (cur > 255) cur = 255;
            end else if (m_buf[i] == 8'h3B) begin
                fields.push_back(cur);
                cur = 0;
            end else begin
                ok = 0;
            end
        end
        fields.push_back(cur);
        if (fields.size() > 2) ok = 0;
        if (!ok) return;
        if (fin == 8'h48 || fin == 8'h66) begin
            m_row = (fields[0] == 0) ? 1 : fields[0];
            m_col = (fields.size() > 1 && fields[1] != 0) ? fields[1] : 1;
        end else if (fin == 8'h4A) begin
            if (fields[0] == 2) exp_q.push_back(mk_cmd(1, 0, 0, 0, 0, 0));
        end else if (fin == 8'h6D) begin
            foreach (fields[i]) model_sgr(fields[i]);
        end
    endtask

    task automatic model_byte(input int b);
        if (m_mode == 0) begin
            if (b >= 8'h20 && b <= 8'h7E) model_putc(b);
            else if (b >= 8'hC0) model_putc(SubCh);
            else if (b == 8'h0D) m_col = 1;
            else if (b == 8'h0A) begin
                if (m_row < 255) m_row++;
                m_col = 1;
            end else if (b == 8'h1B) m_mode = 1;
        end else if (m_mode == 1) begin
            if (b == 8'h5B) begin
                m_mode = 2;
                m_buf.delete();
            end else if (b != 8'h1B) m_mode = 0;
        end else begin
            if (b == 8'h1B) m_mode = 1;
            else if (b >= 8'h40 && b <= 8'h7E) begin
                model_exec(b);
                m_mode = 0;
            end else if (b >= 8'h20 && b <= 8'h3F) m_buf.push_back(b);
        end
    endtask

    // Monitor: sampled on the falling edge, predicting the handshakes of the next rising edge.
    logic [28:0] held, obs;
    bit hold_chk = 0;
    always @(negedge clk) begin
        obs = {bus.out_op, bus.out_row, bus.out_col, bus.out_ch, bus.out_fg, bus.out_bold};
        if (!rst_n) begin
            hold_chk = 0;
        end else begin
            check_eq("busy", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            check_eq("in_ready", 32'(bus.in_ready), 32'(exp_q.size() == 0 || bus.out_ready));
            if (hold_chk) check_eq("hold", 32'(obs), 32'(held));
            hold_chk = bus.out_valid && !bus.out_ready;
            held = obs;
            if (bus.out_valid && bus.out_ready && exp_q.size() != 0)
                check_eq("cmd", 32'(obs), 32'(exp_q.pop_front()));
            if (bus.in_valid && bus.in_ready) model_byte(int'(bus.in_data));
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 3) != 0);
            default: bus.out_ready = 1'b0;
        endcase
    end

    task automatic send_byte(input logic [7:0] b);
        int  n;
        bit  hs;
        n = 0;
        bus.in_data = b;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            hs = bus.in_ready;
            @(posedge clk);
            #1;
            if (hs) break;
            n++;
            if (n > 200) begin
                check_eq("accept_timeout", 32'(n), 32'd0);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_outs", 32'({bus.out_op, bus.out_row, bus.out_col, bus.out_ch, bus.out_fg,
                                  bus.out_bold}), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_token();
        int    r, nf, v, fin;
        string ds;
        r = $urandom_range(0, 99);
        if (r < 40) begin
            send_byte(8'($urandom_range(32, 126)));
        end else if (r < 46) begin
            send_byte(8'hE2); send_byte(8'h96); send_byte(8'h88);
        end else if (r < 52) begin
            send_byte((r < 49) ? 8'h0D : 8'h0A);
        end else if (r < 58) begin
            send_byte(8'($urandom_range(0, 255)));
        end else begin
            send_byte(8'h1B);
            send_byte(($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'h5B);
            case ($urandom_range(0, 5))
                0, 1:    fin = 8'h48;
                2:       fin = 8'h66;
                3:       fin = 8'h6D;
                4:       fin = 8'h4A;
                default: fin = int'($urandom_range(8'h40, 8'h7E));
            endcase
            nf = $urandom_range(0, 3);
            for (int i = 0; i < nf; i++) begin
                if (i > 0) send_byte(8'h3B);
                if (fin == 8'h6D) v = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 1)
                                                                   : $urandom_range(28, 39);
                else if (fin == 8'h4A) v = $urandom_range(0, 3);
                else if ($urandom_range(0, 4) == 0) v = $urandom_range(0, 999);
                else if ($urandom_range(0, 1) == 0) v = $urandom_range(0, 70);
                else v = $urandom_range(185, 210);
                ds = $sformatf("%0d", v);
                foreach (ds[k]) send_byte(ds[k]);
                if ($urandom_range(0, 14) == 0)
                    send_byte(($urandom_range(0, 1) == 0) ? 8'h3F : 8'h0A);
            end
            send_byte(8'(fin));
        end
        if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.out_ready = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        send_str("AB");
        send_str("\033[1;33m\033[5;10H<");
        send_str("\033[0m@");
        send_str("\033[2J\033[H");
        send_str("\033[999;3HZ");
        send_str("\033[3;198H");
        send_byte(8'hE2); send_byte(8'h96); send_byte(8'h88);
        send_str("xyz\033[H");

        // Stall with a command outstanding and a byte pending.
        ready_mode = 2;
        @(posedge clk);
        #2;
        send_byte("Q");
        bus.in_data = "R";
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        ready_mode = 0;
        send_byte("R");

        send_str("\033[?25h\033XK\033[1");
        do_reset();
        send_str("m");

        ready_mode = 1;
        for (int t = 0; t < 700; t++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            send_token();
        end

        ready_mode = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
